wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter.sv | 124 ++++++++++++
 tb/tb_wb_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Register-file write-back arbiter. Merges the ALU result
//                stream (valid/ready) with load returns buffered in a small
//                FIFO. Age-based pre-emption keeps loads from starving, and
//                writes to register 0 are suppressed.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic        we,
    output logic [4:0]  writeaddr,
    output logic [31:0] writedata
);

    localparam int c_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W  = c_AW + 1;
    localparam int c_AGE_W  = $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
    localparam logic [c_AGE_W-1:0] c_AGE_MAX = c_AGE_W'(MAX_WAIT);

    // FIFO storage and bookkeeping
    logic [4:0]          r_mem_addr [DEPTH];
    logic [31:0]         r_mem_data [DEPTH];
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_AGE_W-1:0]  r_age;

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_force;
    logic        w_grant_alu;
    logic        w_grant_ld;
    logic [4:0]  w_gnt_addr;
    logic [31:0] w_gnt_data;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_FULL);
    assign ld_ready = !w_full;
    assign w_push   = ld_valid && !w_full;

    // A head that has waited MAX_WAIT cycles takes the port from the ALU
    assign w_force     = !w_empty && (r_age == c_AGE_MAX);
    assign alu_ready   = !w_force;
    assign w_grant_alu = alu_valid && !w_force;
    assign w_grant_ld  = !w_empty && (w_force || !alu_valid);
    assign w_pop       = w_grant_ld;

    assign w_gnt_addr = w_grant_ld ? r_mem_addr[r_rd_ptr] : alu_addr;
    assign w_gnt_data = w_grant_ld ? r_mem_data[r_rd_ptr] : alu_data;

    // Storage write; contents are don't-care until the count says otherwise
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= ld_addr;
            r_mem_data[r_wr_ptr] <= ld_data;
        end
    end

    // Pointer and occupancy update; entries only become visible next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head age: counts cycles the head sits unserved, saturating at MAX_WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_age <= '0;
        end else if (w_empty || w_pop) begin
            r_age <= '0;
        end else if (r_age != c_AGE_MAX) begin
            r_age <= r_age + c_AGE_W'(1);
        end
    end

    // Registered write port; register 0 grants consume the source silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we        <= 1'b0;
            writeaddr <= '0;
            writedata <= '0;
        end else if ((w_grant_alu || w_grant_ld) && (w_gnt_addr != 5'd0)) begin
            we        <= 1'b1;
            writeaddr <= w_gnt_addr;
            writedata <= w_gnt_data;
        end else begin
            we <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Directed self-checking bench for wb_arbiter
//                (DEPTH = 2, MAX_WAIT = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        we;
    logic [4:0]  writeaddr;
    logic [31:0] writedata;

    int n_cmp = 0;
    int n_err = 0;

    wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .we        (we),
        .writeaddr (writeaddr),
        .writedata (writedata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nw;
        logic [4:0]  got_a [2];
        logic [31:0] got_d [2];

        rst = 1'b1; alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        #1;
        // Reset state
        check("rst_we",        32'(we),        32'd0);
        check("rst_waddr",     32'(writeaddr), 32'd0);
        check("rst_wdata",     writedata,      32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd1);
        check("rst_ld_ready",  32'(ld_ready),  32'd1);
        step(); step();
        #2 rst = 1'b0;
        step();

        // ALU write addr 5
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        #1 check("t1_alu_ready", 32'(alu_ready), 32'd1);
        step();
        alu_valid = 1'b0;
        check("t1_we",       32'(we),        32'd1);
        check("t1_waddr",    32'(writeaddr), 32'd5);
        check("t1_wdata",    writedata,      32'hDEADBEEF);
        check("t1_ld_ready", 32'(ld_ready),  32'd1);
        step();
        check("t1_we_drop",  32'(we),        32'd0);
        check("t1_hold",     32'(writeaddr), 32'd5);

        // Load write addr 7, two-cycle latency
        ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h1234;
        step();
        ld_valid = 1'b0;
        check("t2_no_pass", 32'(we), 32'd0);
        step();
        check("t2_we",    32'(we),        32'd1);
        check("t2_waddr", 32'(writeaddr), 32'd7);
        check("t2_wdata", writedata,      32'h1234);

        // Starvation: ALU always valid, load pre-empts after MAX_WAIT
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hA0;
        ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 32'h99;
        step();
        ld_valid = 1'b0;
        check("t3_alu0", 32'(writeaddr), 32'd3);
        for (int i = 1; i <= 4; i++) begin
            check("t3_ready_hi", 32'(alu_ready), 32'd1);
            step();
            check("t3_alu_wr", 32'(writeaddr), 32'd3);
        end
        check("t3_force_ready", 32'(alu_ready), 32'd0);
        step();
        check("t3_ld_we",    32'(we),        32'd1);
        check("t3_ld_waddr", 32'(writeaddr), 32'd9);
        check("t3_ld_wdata", writedata,      32'h99);
        check("t3_ready_back", 32'(alu_ready), 32'd1);
        step();
        check("t3_alu_resume", 32'(writeaddr), 32'd3);
        check("t3_alu_data",   writedata,      32'hA0);

        // Fill FIFO while ALU busy; third load is refused
        alu_addr = 5'd4; alu_data = 32'h44;
        ld_valid = 1'b1; ld_addr = 5'd10; ld_data = 32'h10A;
        step();
        ld_addr = 5'd11; ld_data = 32'h10B;
        #1 check("t4_ready_one", 32'(ld_ready), 32'd1);
        step();
        ld_addr = 5'd12; ld_data = 32'h10C;
        #1 check("t4_full", 32'(ld_ready), 32'd0);
        step();
        ld_valid = 1'b0; alu_valid = 1'b0;
        nw = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (we && writeaddr != 5'd4) begin
                if (nw < 2) begin
                    got_a[nw] = writeaddr;
                    got_d[nw] = writedata;
                end
                nw++;
            end
        end
        check("t4_nwrites", 32'(nw),       32'd2);
        check("t4_first_a", 32'(got_a[0]), 32'd10);
        check("t4_first_d", got_d[0],      32'h10A);
        check("t4_second_a", 32'(got_a[1]), 32'd11);
        check("t4_second_d", got_d[1],      32'h10B);
        check("t4_ready_end", 32'(ld_ready), 32'd1);

        // Address 0 suppression (ALU, then load)
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFFFFFF;
        #1 check("t5_alu_ready", 32'(alu_ready), 32'd1);
        step();
        alu_valid = 1'b0;
        check("t5_we",    32'(we),        32'd0);
        check("t5_waddr", 32'(writeaddr), 32'd11);
        check("t5_wdata", writedata,      32'h10B);
        ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'h55;
        step();
        ld_valid = 1'b0;
        step();
        check("t5_ld_we",    32'(we),        32'd0);
        check("t5_ld_waddr", 32'(writeaddr), 32'd11);
        // Popped entry frees space: one push while ALU busy leaves room
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h1;
        ld_valid = 1'b1; ld_addr = 5'd20; ld_data = 32'h20;
        step();
        ld_valid = 1'b0; alu_valid = 1'b0;
        check("t5_popped", 32'(ld_ready),  32'd1);
        check("t5_alu1",   32'(writeaddr), 32'd1);
        step();
        check("t5_ld20_a", 32'(writeaddr), 32'd20);
        check("t5_ld20_d", writedata,      32'h20);

        // Async reset with two loads buffered
        alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h2;
        ld_valid = 1'b1; ld_addr = 5'd21; ld_data = 32'h21;
        step();
        ld_addr = 5'd22; ld_data = 32'h22;
        step();
        alu_valid = 1'b0; ld_valid = 1'b0;
        #1 check("t6_full", 32'(ld_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("t6_we",        32'(we),        32'd0);
        check("t6_waddr",     32'(writeaddr), 32'd0);
        check("t6_wdata",     writedata,      32'd0);
        check("t6_ld_ready",  32'(ld_ready),  32'd1);
        check("t6_alu_ready", 32'(alu_ready), 32'd1);
        step();
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t6_no_write", 32'(we), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
